// File: rtl/llr_serializer.sv
// -----------------------------------------------------------------------------
// llr_serializer
//
// Purpose:
//   Receives one symbol per transfer: six signed LLRs and the symbol's Mode.
//   Each LLR is scaled down (arithmetic shift) and saturated to a symmetric
//   soft-bit range when it is written. Symbols are buffered in a small FIFO.
//   They are then emitted one soft bit per cycle over a valid/ready stream.
//   Only the LLRs that the symbol's Mode actually carries are emitted.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   i_valid      input symbol valid
//   o_in_ready   a symbol can be accepted this cycle (combinational from count)
//   Mode         constellation mode of the input symbol
//   i_LLR_0..5   signed input LLRs, LLR_wordlength bits each
//   o_valid      o_LLR / o_bit_idx / o_last are valid
//   i_ready      downstream accepts the current soft bit
//   o_LLR        signed saturated soft bit, OUT_wordlength bits
//   o_bit_idx    index (0..5) of the emitted LLR within its symbol
//   o_last       high on the final LLR (index 5) of a symbol
// -----------------------------------------------------------------------------
module llr_serializer #(
  parameter int LLR_wordlength = 19,
  parameter int OUT_wordlength = 8,
  parameter int SHIFT          = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_valid,
  output logic                             o_in_ready,
  input  logic [2:0]                       Mode,
  input  logic signed [LLR_wordlength-1:0] i_LLR_0,
  input  logic signed [LLR_wordlength-1:0] i_LLR_1,
  input  logic signed [LLR_wordlength-1:0] i_LLR_2,
  input  logic signed [LLR_wordlength-1:0] i_LLR_3,
  input  logic signed [LLR_wordlength-1:0] i_LLR_4,
  input  logic signed [LLR_wordlength-1:0] i_LLR_5,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic signed [OUT_wordlength-1:0] o_LLR,
  output logic [2:0]                       o_bit_idx,
  output logic                             o_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  // Symmetric clip range: the most negative code is never produced.
  localparam logic signed [LLR_wordlength-1:0] SAT_MAX =
    LLR_wordlength'((1 << (OUT_wordlength-1)) - 1);
  localparam logic signed [LLR_wordlength-1:0] SAT_MIN = -SAT_MAX;

  // The FIFO entry stores already-scaled soft bits.
  // It also stores the first index to emit, so Mode is decoded once, at write time.
  typedef struct packed {
    logic [2:0]                          first_idx;
    logic [5:0][OUT_wordlength-1:0]      llr;
  } entry_t;

  typedef enum logic {IDLE, SEND} state_t;

  // Floor shift followed by symmetric saturation.
  function automatic logic [OUT_wordlength-1:0] scale_sat(
    input logic signed [LLR_wordlength-1:0] x
  );
    logic signed [LLR_wordlength-1:0] s;
    s = x >>> SHIFT;
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return s[OUT_wordlength-1:0];
  endfunction

  // Mode carries k soft bits. The emitted indices are 6-k .. 5.
  function automatic logic [2:0] first_idx_of(input logic [2:0] mode);
    case (mode)
      3'd5:    return 3'd0;  // k = 6
      3'd4:    return 3'd1;  // k = 5
      3'd3:    return 3'd2;  // k = 4
      3'd2:    return 3'd3;  // k = 3
      default: return 3'd4;  // k = 2 for modes 0, 1, 6, 7
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Input formatting
  // ---------------------------------------------------------------------------
  entry_t wr_entry;

  always_comb begin
    wr_entry.first_idx = first_idx_of(Mode);
    wr_entry.llr[0]    = scale_sat(i_LLR_0);
    wr_entry.llr[1]    = scale_sat(i_LLR_1);
    wr_entry.llr[2]    = scale_sat(i_LLR_2);
    wr_entry.llr[3]    = scale_sat(i_LLR_3);
    wr_entry.llr[4]    = scale_sat(i_LLR_4);
    wr_entry.llr[5]    = scale_sat(i_LLR_5);
  end

  // ---------------------------------------------------------------------------
  // Symbol FIFO
  // ---------------------------------------------------------------------------
  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            fifo_empty, fifo_full;
  logic            push, pop;
  state_t          state;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  // Gated by rst so upstream sees "not ready" for the whole reset interval.
  assign o_in_ready = !rst && !fifo_full;
  assign push       = i_valid && o_in_ready;
  assign head       = mem[rd_ptr];

  // Pop occurs in two cases. In IDLE, when a symbol is waiting. Or on the final
  // handshake of the current symbol, when another one is already queued. The
  // second case removes the bubble between back-to-back symbols.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE)                                pop = 1'b1;
      else if (i_ready && o_bit_idx == 3'd5)            pop = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;  // idle, or push and pop together: occupancy unchanged
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it has been written, as gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // ---------------------------------------------------------------------------
  // Output FSM: holding register plus registered stream outputs
  // ---------------------------------------------------------------------------
  logic [5:0][OUT_wordlength-1:0] hold_llr;
  logic [2:0]                     next_idx;

  assign next_idx = o_bit_idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_llr  <= '0;
      o_valid   <= 1'b0;
      o_LLR     <= '0;
      o_bit_idx <= '0;
      o_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            hold_llr  <= head.llr;
            o_LLR     <= $signed(head.llr[head.first_idx]);
            o_bit_idx <= head.first_idx;
            o_last    <= (head.first_idx == 3'd5);
            o_valid   <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Outputs change only on a handshake. Otherwise they hold.
          if (i_ready) begin
            if (o_bit_idx != 3'd5) begin
              o_LLR     <= $signed(hold_llr[next_idx]);
              o_bit_idx <= next_idx;
              o_last    <= (next_idx == 3'd5);
            end else if (!fifo_empty) begin
              hold_llr  <= head.llr;
              o_LLR     <= $signed(head.llr[head.first_idx]);
              o_bit_idx <= head.first_idx;
              o_last    <= (head.first_idx == 3'd5);
            end else begin
              o_valid   <= 1'b0;
              o_last    <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_llr_serializer.sv
// -----------------------------------------------------------------------------
// tb_llr_serializer
//
// Self-checking bench for llr_serializer. A background monitor samples the
// stream on the falling clock edge. It compares every handshaken beat against a
// queue of expected beats, which a behavioural model builds from each accepted
// symbol. The model uses floor division, clipping and a Mode-to-bit-count table.
// The monitor also checks that outputs hold while stalled. Scenario tasks drive
// stimulus and check their own scenario-specific properties.
// -----------------------------------------------------------------------------
module tb_llr_serializer;

  localparam int LW  = 19;
  localparam int OW  = 8;
  localparam int SH  = 4;
  localparam int SAT = 127;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_valid = 1'b0;
  logic                 i_ready = 1'b0;
  logic [2:0]           mode = 3'd0;
  logic signed [LW-1:0] llr_in [6];
  logic                 o_in_ready;
  logic                 o_valid;
  logic signed [OW-1:0] o_LLR;
  logic [2:0]           o_bit_idx;
  logic                 o_last;

  llr_serializer #(
    .LLR_wordlength(LW),
    .OUT_wordlength(OW),
    .SHIFT(SH),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .o_in_ready(o_in_ready),
    .Mode(mode),
    .i_LLR_0(llr_in[0]),
    .i_LLR_1(llr_in[1]),
    .i_LLR_2(llr_in[2]),
    .i_LLR_3(llr_in[3]),
    .i_LLR_4(llr_in[4]),
    .i_LLR_5(llr_in[5]),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_LLR(o_LLR),
    .o_bit_idx(o_bit_idx),
    .o_last(o_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int idx;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  beat_t seen_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int ref_soft(input int v);
    int d;
    int q;
    d = 1 << SH;
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);   // floor for negatives
    if (q > SAT)  q = SAT;
    if (q < -SAT) q = -SAT;
    return q;
  endfunction

  function automatic int bits_for_mode(input logic [2:0] m);
    case (m)
      3'd5:    return 6;
      3'd4:    return 5;
      3'd3:    return 4;
      3'd2:    return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_accept();
    int k;
    k = bits_for_mode(mode);
    for (int b = 6 - k; b < 6; b++) begin
      beat_t e;
      e.val  = ref_soft(int'(llr_in[b]));
      e.idx  = b;
      e.last = (b == 5);
      exp_q.push_back(e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic signed [LW-1:0] rand_llr();
    logic [LW-1:0] r;
    r = LW'($urandom);
    return $signed(r) >>> $urandom_range(0, 12);
  endfunction

  task automatic rand_symbol(input logic [2:0] m);
    mode = m;
    for (int i = 0; i < 6; i++) llr_in[i] = rand_llr();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stream monitor (falling edge: inputs and outputs are both stable there)
  // ---------------------------------------------------------------------------
  task automatic monitor();
    bit                   hold_pending = 1'b0;
    logic signed [OW-1:0] prev_llr = '0;
    logic [2:0]           prev_idx = '0;
    logic                 prev_last = 1'b0;
    beat_t                e;
    beat_t                s;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          n_cmp++;
          if (o_valid !== 1'b1 || o_LLR !== prev_llr || o_bit_idx !== prev_idx || o_last !== prev_last) begin
            n_err++;
            $display("FAIL hold_stable: got v=%b llr=%0d idx=%0d last=%b, required v=1 llr=%0d idx=%0d last=%b",
                     o_valid, o_LLR, o_bit_idx, o_last, prev_llr, prev_idx, prev_last);
          end
        end
        if (o_valid && i_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: got llr=%0d idx=%0d last=%b, required no beat",
                     o_LLR, o_bit_idx, o_last);
          end else begin
            e = exp_q.pop_front();
            if (int'(o_LLR) !== e.val || o_bit_idx !== 3'(e.idx) || o_last !== e.last) begin
              n_err++;
              $display("FAIL beat: got llr=%0d idx=%0d last=%b, required llr=%0d idx=%0d last=%b",
                       o_LLR, o_bit_idx, o_last, e.val, e.idx, e.last);
            end
          end
          s.val  = int'(o_LLR);
          s.idx  = int'(o_bit_idx);
          s.last = o_last;
          seen_q.push_back(s);
        end
        hold_pending = o_valid && !i_ready;
        prev_llr     = o_LLR;
        prev_idx     = o_bit_idx;
        prev_last    = o_last;
        if (i_valid && o_in_ready) model_accept();
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || o_valid) && c < 500) begin
      tick();
      c++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d beats pending, o_valid=%b, required 0 pending and o_valid=0",
               name, exp_q.size(), o_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    repeat (2) tick();
    n_cmp++; if (o_valid !== 1'b0)    begin n_err++; $display("FAIL reset_o_valid: got %b, required 0", o_valid); end
    n_cmp++; if (o_LLR !== '0)        begin n_err++; $display("FAIL reset_o_LLR: got %0d, required 0", o_LLR); end
    n_cmp++; if (o_bit_idx !== 3'd0)  begin n_err++; $display("FAIL reset_o_bit_idx: got %0d, required 0", o_bit_idx); end
    n_cmp++; if (o_last !== 1'b0)     begin n_err++; $display("FAIL reset_o_last: got %b, required 0", o_last); end
    n_cmp++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b, required 0", o_in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b, required 1", o_in_ready); end
    tick();
  endtask

  task automatic test_mode5_directed();
    int exp_v [6] = '{6, -13, 127, -127, 1, -1};
    seen_q.delete();
    i_ready = 1'b1;
    mode = 3'd5;
    llr_in[0] = 19'sd100;   llr_in[1] = -19'sd200;
    llr_in[2] = 19'sd4000;  llr_in[3] = -19'sd4000;
    llr_in[4] = 19'sd16;    llr_in[5] = -19'sd16;
    i_valid = 1'b1;
    tick();                 // symbol written on this edge
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got o_valid=%b, required 0", o_valid); end
    tick();
    n_cmp++;
    if (o_valid !== 1'b1 || o_bit_idx !== 3'd0) begin
      n_err++; $display("FAIL latency_first: got o_valid=%b idx=%0d, required o_valid=1 idx=0", o_valid, o_bit_idx);
    end
    wait_drain("mode5");
    n_cmp++; if (seen_q.size() != 6) begin n_err++; $display("FAIL mode5_count: got %0d, required 6", seen_q.size()); end
    for (int i = 0; i < 6 && i < seen_q.size(); i++) begin
      n_cmp++;
      if (seen_q[i].val != exp_v[i] || seen_q[i].idx != i || seen_q[i].last != (i == 5)) begin
        n_err++;
        $display("FAIL mode5_beat%0d: got llr=%0d idx=%0d last=%b, required llr=%0d idx=%0d last=%b",
                 i, seen_q[i].val, seen_q[i].idx, seen_q[i].last, exp_v[i], i, (i == 5));
      end
    end
  endtask

  task automatic test_two_bit_modes();
    logic [2:0] modes [2] = '{3'd0, 3'd7};
    seen_q.delete();
    i_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      rand_symbol(modes[m]);
      llr_in[4] = 19'sd32;
      llr_in[5] = -19'sd33;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      wait_drain("two_bit");
    end
    n_cmp++; if (seen_q.size() != 4) begin n_err++; $display("FAIL two_bit_count: got %0d, required 4", seen_q.size()); end
    for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
      n_cmp++;
      if (seen_q[i].val != ((i % 2) ? -3 : 2) || seen_q[i].idx != ((i % 2) ? 5 : 4) || seen_q[i].last != (i % 2 == 1)) begin
        n_err++;
        $display("FAIL two_bit_beat%0d: got llr=%0d idx=%0d last=%b, required llr=%0d idx=%0d last=%b",
                 i, seen_q[i].val, seen_q[i].idx, seen_q[i].last, (i % 2) ? -3 : 2, (i % 2) ? 5 : 4, (i % 2 == 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int gaps;
    seen_q.delete();
    i_ready = 1'b1;
    rand_symbol(3'd3); i_valid = 1'b1;
    tick();
    rand_symbol(3'd3);
    tick();
    rand_symbol(3'd3);
    gaps = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_valid !== 1'b1) gaps++;
      tick();
      if (c == 0) i_valid = 1'b0;
    end
    n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL b2b_bubbles: got %0d cycles without o_valid, required 0", gaps); end
    wait_drain("b2b");
    n_cmp++; if (seen_q.size() != 12) begin n_err++; $display("FAIL b2b_count: got %0d, required 12", seen_q.size()); end
    for (int i = 0; i < 12 && i < seen_q.size(); i++) begin
      n_cmp++;
      if (seen_q[i].idx != 2 + (i % 4) || seen_q[i].last != (i % 4 == 3)) begin
        n_err++;
        $display("FAIL b2b_idx%0d: got idx=%0d last=%b, required idx=%0d last=%b",
                 i, seen_q[i].idx, seen_q[i].last, 2 + (i % 4), (i % 4 == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    int                   accepted;
    logic signed [OW-1:0] snap_llr;
    logic [2:0]           snap_idx;
    bit                   acc;
    seen_q.delete();
    i_ready = 1'b0;
    accepted = 0;
    rand_symbol(3'd5);
    i_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = o_in_ready;
      if (acc) accepted++;
      @(posedge clk);
      #1;
      if (acc) rand_symbol(3'd5);
    end
    n_cmp++; if (accepted != 5) begin n_err++; $display("FAIL capacity: got %0d accepted, required 5", accepted); end
    n_cmp++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b, required 0", o_in_ready); end
    snap_llr = o_LLR;
    snap_idx = o_bit_idx;
    repeat (3) tick();
    n_cmp++;
    if (o_valid !== 1'b1 || o_LLR !== snap_llr || o_bit_idx !== snap_idx) begin
      n_err++;
      $display("FAIL stall_hold: got v=%b llr=%0d idx=%0d, required v=1 llr=%0d idx=%0d",
               o_valid, o_LLR, o_bit_idx, snap_llr, snap_idx);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    wait_drain("backpressure");
    n_cmp++; if (seen_q.size() != 30) begin n_err++; $display("FAIL backpressure_count: got %0d, required 30", seen_q.size()); end
  endtask

  task automatic test_stall_mid();
    int held;
    int stalls;
    seen_q.delete();
    i_ready = 1'b1;
    rand_symbol(3'd5);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    held = 0;
    stalls = 0;
    for (int c = 0; c < 40 && (exp_q.size() != 0 || o_valid); c++) begin
      if (o_valid && o_bit_idx == 3'd2) begin
        held++;
        if (stalls < 2) begin i_ready = 1'b0; stalls++; end
        else i_ready = 1'b1;
      end else begin
        i_ready = 1'b1;
      end
      tick();
    end
    i_ready = 1'b1;
    wait_drain("stall");
    n_cmp++; if (held != 3) begin n_err++; $display("FAIL stall_idx2_cycles: got %0d, required 3", held); end
    n_cmp++; if (seen_q.size() != 6) begin n_err++; $display("FAIL stall_count: got %0d, required 6", seen_q.size()); end
    for (int i = 0; i < 6 && i < seen_q.size(); i++) begin
      n_cmp++;
      if (seen_q[i].idx != i) begin
        n_err++; $display("FAIL stall_idx%0d: got %0d, required %0d", i, seen_q[i].idx, i);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    acc = 1'b0;
    i_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!i_valid || acc) begin
        i_valid = ($urandom_range(0, 3) != 0);
        rand_symbol(3'($urandom_range(0, 7)));
      end
      i_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = i_valid && o_in_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    wait_drain("random");
  endtask

  task automatic test_reset_mid();
    int stale;
    seen_q.delete();
    i_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rand_symbol(3'd5);
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    repeat (2) tick();
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_sending: got o_valid=%b, required 1", o_valid); end
    #2;
    rst = 1'b1;             // asserted between clock edges
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_valid: got %b, required 0", o_valid); end
    n_cmp++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL async_reset_in_ready: got %b, required 0", o_in_ready); end
    exp_q.delete();
    seen_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b, required 1", o_in_ready); end
    i_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      tick();
      if (o_valid !== 1'b0) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL stale_beats: got %0d cycles with o_valid, required 0", stale); end
    rand_symbol(3'd2);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    wait_drain("post_reset");
    n_cmp++; if (seen_q.size() != 3) begin n_err++; $display("FAIL post_reset_count: got %0d, required 3", seen_q.size()); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 6; i++) llr_in[i] = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_mode5_directed();
    test_two_bit_modes();
    test_back_to_back();
    test_backpressure();
    test_stall_mid();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
